// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants and fetch FSM encoding for the I2S blocks
// Purpose : frame geometry, channel encodings and fetch states used by
//           i2s_writer (and later i2s_reader).
// Ports   : none (package).
package i2s_pkg;

   localparam int SAMPLE_BITS = 24;
   localparam int SLOT_BITS   = 32;
   localparam int FRAME_BITS  = 64;

   localparam int BIT_CNT_W   = $clog2(FRAME_BITS);
   localparam int SLOT_POS_W  = $clog2(SLOT_BITS);

   // First bit index of the right slot, and last slot position carrying data
   // (position 0 is the one-bit I2S delay, so data sits at 1..SAMPLE_BITS).
   localparam logic [BIT_CNT_W-1:0]  RIGHT_SLOT_START = BIT_CNT_W'(SLOT_BITS);
   localparam logic [SLOT_POS_W-1:0] LAST_DATA_POS    = SLOT_POS_W'(SAMPLE_BITS);

   localparam logic LR_LEFT  = 1'b0;
   localparam logic LR_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      REQUEST      = 2'd1,
      WAIT_ACK_LOW = 2'd2
   } fetch_state_e;

   // Channel owning a given frame bit index.
   function automatic logic slot_channel(input logic [BIT_CNT_W-1:0] bit_idx);
      return (bit_idx >= RIGHT_SLOT_START) ? LR_RIGHT : LR_LEFT;
   endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// rtl/i2s_clock_gen.sv - SCK divider with falling-edge strobe
// Purpose : divides clk by 2*CLOCK_DIVIDE to make SCK and flags the clk cycle
//           on which SCK falls.
// Ports   : clk, rst (sync, active-high), enable_i (low holds idle),
//           sck_o (bit clock), sck_fall_o (one-clk strobe, SCK falls this edge).
module i2s_clock_gen #(
   parameter int CLOCK_DIVIDE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic enable_i,
   output logic sck_o,
   output logic sck_fall_o
);

   logic [7:0] div_count_q, div_count_d;
   logic       sck_q, sck_d;
   logic       terminal;

   assign terminal = (div_count_q == 8'(CLOCK_DIVIDE - 1));

   always_comb begin
      div_count_d = div_count_q + 8'd1;
      sck_d       = sck_q;
      if (terminal) begin
         div_count_d = '0;
         sck_d       = ~sck_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !enable_i) begin
         div_count_q <= '0;
         sck_q       <= 1'b0;
      end else begin
         div_count_q <= div_count_d;
         sck_q       <= sck_d;
      end
   end

   assign sck_o      = sck_q;
   assign sck_fall_o = enable_i & terminal & sck_q;

endmodule

// File: rtl/i2s_writer.sv
// rtl/i2s_writer.sv - sample fetch, staging and Philips I2S serialiser
// Purpose : fetches one 24-bit sample per slot over a four-phase req/ack
//           handshake, stages it, and shifts it out MSB first with the
//           one-bit I2S delay; zero-fills and flags underrun / L-R mismatch.
// Ports   : clk, rst (sync, active-high), enable (low forces idle);
//           audio_data_request / audio_data_ack / audio_data / audio_lr_bit
//           (upstream handshake); i2s_sck / i2s_lrck / i2s_sdata (pins);
//           underrun, sync_error (one-clk flag pulses).
module i2s_writer
   import i2s_pkg::*;
#(
   parameter int CLOCK_DIVIDE = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   output logic                   audio_data_request,
   input  logic                   audio_data_ack,
   input  logic [SAMPLE_BITS-1:0] audio_data,
   input  logic                   audio_lr_bit,
   output logic                   i2s_sck,
   output logic                   i2s_lrck,
   output logic                   i2s_sdata,
   output logic                   underrun,
   output logic                   sync_error
);

   logic sck, sck_fall;

   i2s_clock_gen #(.CLOCK_DIVIDE(CLOCK_DIVIDE)) u_clock_gen (
      .clk       (clk),
      .rst       (rst),
      .enable_i  (enable),
      .sck_o     (sck),
      .sck_fall_o(sck_fall)
   );

   logic [BIT_CNT_W-1:0]   bit_count_q, bit_count_d, next_bit;
   logic [SLOT_POS_W-1:0]  slot_pos;
   logic                   started_q, started_d;
   logic                   slot_chan;
   logic                   lrck_q, lrck_d;
   logic                   sdata_q, sdata_d;
   logic                   underrun_q, underrun_d;
   logic                   sync_error_q, sync_error_d;
   logic [SAMPLE_BITS-1:0] shift_q, shift_d;
   logic                   stage_take;

   fetch_state_e           state_q;
   logic                   request_q;
   logic                   stage_full_q;
   logic [SAMPLE_BITS-1:0] stage_data_q;
   logic                   stage_lr_q;

   // bit_count rests at 0 after reset but no bit has been entered yet; the
   // first SCK fall must enter bit 0 (left slot load), not advance to bit 1.
   assign next_bit  = started_q ? bit_count_q + 1'b1 : '0;
   assign slot_pos  = next_bit[SLOT_POS_W-1:0];
   assign slot_chan = slot_channel(next_bit);

   always_comb begin
      bit_count_d  = bit_count_q;
      started_d    = started_q;
      lrck_d       = lrck_q;
      sdata_d      = sdata_q;
      shift_d      = shift_q;
      underrun_d   = 1'b0;
      sync_error_d = 1'b0;
      stage_take   = 1'b0;
      if (sck_fall) begin
         bit_count_d = next_bit;
         started_d   = 1'b1;
         lrck_d      = slot_chan;
         sdata_d     = 1'b0;
         if (slot_pos == '0) begin
            if (!stage_full_q) begin
               shift_d    = '0;
               underrun_d = 1'b1;
            end else if (stage_lr_q != slot_chan) begin
               // Leave the sample staged; it belongs to the next slot.
               shift_d      = '0;
               sync_error_d = 1'b1;
            end else begin
               shift_d    = stage_data_q;
               stage_take = 1'b1;
            end
         end else if (slot_pos <= LAST_DATA_POS) begin
            sdata_d = shift_q[SAMPLE_BITS-1];
            shift_d = {shift_q[SAMPLE_BITS-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         bit_count_q  <= '0;
         started_q    <= 1'b0;
         lrck_q       <= 1'b0;
         sdata_q      <= 1'b0;
         shift_q      <= '0;
         underrun_q   <= 1'b0;
         sync_error_q <= 1'b0;
         state_q      <= IDLE;
         request_q    <= 1'b0;
         stage_full_q <= 1'b0;
         stage_data_q <= '0;
         stage_lr_q   <= 1'b0;
      end else begin
         bit_count_q  <= bit_count_d;
         started_q    <= started_d;
         lrck_q       <= lrck_d;
         sdata_q      <= sdata_d;
         shift_q      <= shift_d;
         underrun_q   <= underrun_d;
         sync_error_q <= sync_error_d;

         // Staging is never full in REQUEST, so a take and a capture
         // cannot collide on the same edge.
         if (stage_take) begin
            stage_full_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (!stage_full_q) begin
                  state_q   <= REQUEST;
                  request_q <= 1'b1;
               end
            end
            REQUEST: begin
               if (audio_data_ack) begin
                  stage_data_q <= audio_data;
                  stage_lr_q   <= audio_lr_bit;
                  stage_full_q <= 1'b1;
                  request_q    <= 1'b0;
                  state_q      <= WAIT_ACK_LOW;
               end
            end
            WAIT_ACK_LOW: begin
               request_q <= 1'b0;
               if (!audio_data_ack) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               request_q <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   // Request is gated so it drops in the same cycle enable falls.
   assign audio_data_request = request_q & enable;
   assign i2s_sck            = sck;
   assign i2s_lrck           = lrck_q;
   assign i2s_sdata          = sdata_q;
   assign underrun           = underrun_q;
   assign sync_error         = sync_error_q;

endmodule

// File: tb/tb_i2s_writer.sv
// tb/tb_i2s_writer.sv - scoreboard bench for i2s_writer
module tb_i2s_writer;

   localparam int CD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        audio_data_request;
   wire logic   audio_data_ack;
   wire logic [23:0] audio_data;
   wire logic   audio_lr_bit;
   logic        i2s_sck, i2s_lrck, i2s_sdata, underrun, sync_error;

   // Upstream drive: automatic responder or manual override.
   logic        man_mode = 1'b0, man_ack = 1'b0, man_lr = 1'b0;
   logic [23:0] man_data = '0;
   logic        rsp_ack = 1'b0, rsp_lr = 1'b0;
   logic [23:0] rsp_data = '0;
   assign audio_data_ack = man_mode ? man_ack  : rsp_ack;
   assign audio_data     = man_mode ? man_data : rsp_data;
   assign audio_lr_bit   = man_mode ? man_lr   : rsp_lr;

   always #5 clk = ~clk;

   i2s_writer #(.CLOCK_DIVIDE(CD)) dut (
      .clk               (clk),
      .rst               (rst),
      .enable            (enable),
      .audio_data_request(audio_data_request),
      .audio_data_ack    (audio_data_ack),
      .audio_data        (audio_data),
      .audio_lr_bit      (audio_lr_bit),
      .i2s_sck           (i2s_sck),
      .i2s_lrck          (i2s_lrck),
      .i2s_sdata         (i2s_sdata),
      .underrun          (underrun),
      .sync_error        (sync_error)
   );

   typedef struct {
      logic [31:0] word;
      logic        lr;
      int          ur;
      int          se;
   } slot_exp_t;

   typedef struct {
      logic        lr;
      logic [23:0] data;
   } feed_t;

   slot_exp_t sb[$];
   feed_t     feed_q[$];

   int n_cmp = 0;
   int n_err = 0;
   int ack_delay = 1;
   int ack_hold = 0;
   int req_during_ack = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] slot_word(input logic [23:0] d);
      return {1'b0, d, 7'b0};
   endfunction

   task automatic push_slot(input logic [23:0] d, input logic lr, input int ur, input int se);
      slot_exp_t e;
      e.word = (ur != 0 || se != 0) ? 32'h0 : slot_word(d);
      e.lr   = lr;
      e.ur   = ur;
      e.se   = se;
      sb.push_back(e);
   endtask

   task automatic push_feed(input logic lr, input logic [23:0] d);
      feed_t f;
      f.lr   = lr;
      f.data = d;
      feed_q.push_back(f);
   endtask

   // I2S receiver: samples SDATA/LRCK on SCK rising edges.
   int          cyc = 0;
   int          rises = 0, mon_idx = 0, mon_ur = 0, mon_se = 0, n_slot = 0;
   int          last_rise_cyc = 0, sck_period = 0, sck_high = 0;
   logic [31:0] mon_word = '0;
   logic        mon_lr = 1'b0, mon_lr_bad = 1'b0, prev_sck = 1'b0;

   initial begin : monitor
      slot_exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst || !enable) begin
            rises = 0; mon_idx = 0; mon_ur = 0; mon_se = 0;
            mon_word = '0; mon_lr_bad = 1'b0; prev_sck = 1'b0;
         end else begin
            if (underrun)   mon_ur++;
            if (sync_error) mon_se++;
            if (i2s_sck && !prev_sck) begin
               if (rises > 0) sck_period = cyc - last_rise_cyc;
               last_rise_cyc = cyc;
               rises++;
               // The first rise after start precedes frame bit 0.
               if (rises > 1) begin
                  if (mon_idx == 0) mon_lr = i2s_lrck;
                  else if (i2s_lrck !== mon_lr) mon_lr_bad = 1'b1;
                  mon_word = {mon_word[30:0], i2s_sdata};
                  mon_idx++;
                  if (mon_idx == 32) begin
                     if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check_val($sformatf("slot%0d_word", n_slot), mon_word, e.word);
                        check_val($sformatf("slot%0d_lrck", n_slot),
                                  mon_lr_bad ? 32'd2 : {31'd0, mon_lr}, {31'd0, e.lr});
                        check_val($sformatf("slot%0d_underrun", n_slot), mon_ur, e.ur);
                        check_val($sformatf("slot%0d_sync_error", n_slot), mon_se, e.se);
                        n_slot++;
                     end
                     mon_idx = 0; mon_word = '0; mon_ur = 0; mon_se = 0; mon_lr_bad = 1'b0;
                  end
               end
            end
            if (!i2s_sck && prev_sck) sck_high = cyc - last_rise_cyc;
            prev_sck = i2s_sck;
         end
      end
   end

   initial begin : responder
      feed_t f;
      int    hold;
      forever begin
         @(negedge clk);
         if (!man_mode && audio_data_request && !rsp_ack && feed_q.size() > 0) begin
            repeat (ack_delay) @(negedge clk);
            f = feed_q.pop_front();
            rsp_data = f.data;
            rsp_lr   = f.lr;
            rsp_ack  = 1'b1;
            hold = 0;
            do begin
               @(negedge clk);
               hold++;
               if (audio_data_request) req_during_ack++;
            end while ((audio_data_request || hold < ack_hold) && hold < 1000);
            rsp_ack = 1'b0;
         end
      end
   end

   task automatic wait_sb(input string tag, input int max_cyc);
      int n = 0;
      while (sb.size() != 0 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check_val(tag, 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_request"},    audio_data_request, 1'b0);
      check_val({tag, "_sck"},        i2s_sck,    1'b0);
      check_val({tag, "_lrck"},       i2s_lrck,   1'b0);
      check_val({tag, "_sdata"},      i2s_sdata,  1'b0);
      check_val({tag, "_underrun"},   underrun,   1'b0);
      check_val({tag, "_sync_error"}, sync_error, 1'b0);
   endtask

   task automatic run_scenario(input string tag);
      enable = 1'b1;
      wait_sb(tag, 1500);
      enable = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin : main
      int n;
      rst    = 1'b1;
      enable = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst    = 1'b0;
      enable = 1'b0;
      repeat (3) @(negedge clk);

      // Divider / idle underrun: no acks at all.
      push_slot(24'h0, 1'b0, 1, 0);
      push_slot(24'h0, 1'b1, 1, 0);
      run_scenario("divider_drain");
      check_val("sck_period", sck_period, 2 * CD);
      check_val("sck_high",   sck_high,   CD);

      // Stereo frame with prompt acks.
      ack_delay = 2;
      push_feed(1'b0, 24'hA5A5A5);
      push_feed(1'b1, 24'h123456);
      push_slot(24'hA5A5A5, 1'b0, 0, 0);
      push_slot(24'h123456, 1'b1, 0, 0);
      run_scenario("stereo_drain");

      // Right sample offered while a left slot is next.
      ack_delay = 1;
      push_feed(1'b1, 24'h5A0F3C);
      push_slot(24'h0,      1'b0, 0, 1);
      push_slot(24'h5A0F3C, 1'b1, 0, 0);
      run_scenario("mismatch_drain");

      // Long ack hold: request must stay low while ack is high.
      ack_hold = 10;
      req_during_ack = 0;
      push_feed(1'b0, 24'h7FFFFF);
      push_feed(1'b1, 24'h800000);
      push_slot(24'h7FFFFF, 1'b0, 0, 0);
      push_slot(24'h800000, 1'b1, 0, 0);
      run_scenario("hold_drain");
      check_val("req_during_ack", req_during_ack, 0);
      check_val("hold_feed_used", 32'(feed_q.size()), 0);
      ack_hold = 0;

      // Enable drop around bit 12 of the left slot, with a right sample staged.
      push_feed(1'b0, 24'h3C3C3C);
      push_feed(1'b1, 24'h0F0F0F);
      enable = 1'b1;
      n = 0;
      while (mon_idx != 12 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check_val("drop_reach_bit12", (n < 1000), 1'b1);
      enable = 1'b0;
      @(negedge clk);
      check_idle_outputs("drop");
      check_val("drop_feed_used", 32'(feed_q.size()), 0);
      feed_q.delete();
      repeat (4) @(negedge clk);
      push_slot(24'h0, 1'b0, 1, 0);
      push_slot(24'h0, 1'b1, 1, 0);
      run_scenario("reenable_drain");

      // Reset landing mid-handshake with ack held through it.
      man_mode = 1'b1;
      man_ack  = 1'b0;
      enable   = 1'b1;
      n = 0;
      while (!audio_data_request && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_val("rst_req_seen", audio_data_request, 1'b1);
      man_data = 24'h654321;
      man_lr   = 1'b0;
      man_ack  = 1'b1;
      rst      = 1'b1;
      @(negedge clk);
      check_idle_outputs("rst_mid");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      push_slot(24'h654321, 1'b0, 0, 0);
      push_slot(24'h0,      1'b1, 1, 0);
      n = 0;
      while (!audio_data_request && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_val("rst_req_reassert", audio_data_request, 1'b1);
      n = 0;
      while (audio_data_request && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_val("rst_capture", audio_data_request, 1'b0);
      man_ack = 1'b0;
      wait_sb("rst_drain", 1500);
      enable = 1'b0;
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/i2s_writer.md
Name: i2s_writer

Overview:
- Consumer of the audio sample handshake driven by the memory controller; sits directly downstream of it, in the same clock domain as that controller's read side.
- Fetches one 24-bit sample per audio slot using a four-phase request/ack handshake and stages it.
- Serialises samples onto standard Philips I2S pins (SCK, LRCK, SDATA) using a bit clock divided from clk.
- Zero-fills slots on underrun or on left/right mismatch, and flags both conditions.

Parameters:
CLOCK_DIVIDE, 4, clk cycles per SCK half-period; legal range 1..255.

Ports:
clk  in  1  I2S-domain clock; SCK is derived from it.
rst  in  1  synchronous, active-high reset.
enable  in  1  run control; low forces idle.
audio_data_request  out  1  high while the writer wants a sample.
audio_data_ack  in  1  upstream asserts with valid data; held until request falls.
audio_data  in  24  sample, two's complement, MSB first on the wire.
audio_lr_bit  in  1  0 = left channel, 1 = right channel.
i2s_sck  out  1  bit clock.
i2s_lrck  out  1  word select: 0 = left slot, 1 = right slot.
i2s_sdata  out  1  serial data.
underrun  out  1  one-clk pulse: slot began with no staged sample.
sync_error  out  1  one-clk pulse: staged sample's lr_bit mismatched the slot.

Behaviour:
- Reset: all outputs 0; div_count=0, bit_count=0, staging empty, shift register 0, fetch FSM IDLE.
- enable low: same state as reset, held every cycle. Request drops immediately; upstream clears ack on its own.
- Clock divider: div_count counts 0..CLOCK_DIVIDE-1. At the terminal count, i2s_sck toggles and div_count returns to 0.
  - sck_fall = terminal count while i2s_sck==1.
  - All of lrck, sdata and bit_count update only on the sck_fall cycle, in the same register edge as SCK falling.
- Frame timing:
  - bit_count is 6-bit, incremented on each sck_fall, wraps 63->0.
  - Left slot = bits 0..31 (lrck=0); right slot = 32..63 (lrck=1).
  - lrck changes at the fall that enters bit 0 or bit 32.
  - One-bit I2S delay: slot bit 0 is 0, slot bits 1..24 carry sample[23..0], slot bits 25..31 are 0.
- Slot load (sck_fall entering bit 0 or 32), checked in this order:
  - Staging empty: shift register loaded 0; underrun pulses.
  - Staging full and lr_bit != slot channel: shift register loaded 0; sync_error pulses; sample stays staged for the next slot.
  - Otherwise: shift register loaded with the sample; staging emptied.
- Shift: on each sck_fall in slot bits 1..24, sdata <= shift MSB and the register shifts left. Otherwise sdata <= 0.
- Fetch FSM (2-bit, advances every clk):
  - IDLE: if staging empty -> REQUEST. request is asserted on the following clk.
  - REQUEST: request=1. On ack=1, capture data and lr_bit into staging, mark full, request <= 0 -> WAIT_ACK_LOW.
  - WAIT_ACK_LOW: request=0; when ack==0 -> IDLE.
  - ack high in IDLE or WAIT_ACK_LOW is ignored; no capture.
- Simultaneous events:
  - Slot-load emptying staging and a capture on the same clk cannot occur, because staging is full in neither REQUEST nor IDLE->REQUEST.
  - A capture landing on a slot-load cycle is too late for that slot: the slot underruns and the sample goes to the next matching slot.
- First frame after enable rises starts at bit 0, left slot. It underruns unless a sample is captured within the first SCK period.

Decomposition:
- Package i2s_pkg holds:
  - SAMPLE_BITS=24, SLOT_BITS=32, FRAME_BITS=64
  - LR_LEFT=0, LR_RIGHT=1
  - fetch FSM encodings: IDLE, REQUEST, WAIT_ACK_LOW
- Sub-module i2s_clock_gen holds div_count and the SCK register and produces sck plus the sck_fall strobe. It is shared with a future i2s_reader.
- Slot logic, shift register and fetch FSM stay in i2s_writer.

Test Plan:
- Divider check: CLOCK_DIVIDE=4, enable=1, no acks -> SCK period 8 clk; lrck toggles every 32 SCK; sdata constantly 0; underrun pulses at each slot start.
- Stereo frame: upstream acks within 3 clk of request, supplying L=0xA5A5A5 (lr=0) then R=0x123456 (lr=1).
  - Left slot: bit 0 is 0, bits 1..24 serialise 0xA5A5A5 MSB first, bits 25..31 are 0.
  - Right slot: serialises 0x123456.
  - No flags.
- Handshake discipline: upstream holds ack high for 10 clk -> request stays low until ack falls and the FSM passes IDLE; exactly one capture per ack pulse.
- Mismatch: feed lr=1 sample while a left slot is next -> left slot zeros with a sync_error pulse; following right slot carries the sample; no underrun.
- Enable drop mid-slot (at bit 12): one clk later all outputs are 0, bit_count is 0 and staging is empty. Re-enable restarts at left slot bit 0.
- Reset mid-handshake (request=1, ack=1): the next cycle matches the reset values; the held ack is not captured after reset release until request is re-asserted.
